bus_arbiter_4src: RTL and testbench

BUS_ARBITER_4SRC -- requirements
Module: bus_arbiter_4src

---
 rtl/bus_arbiter_4src.sv | 109 ++++++++++
 tb/tb_bus_arbiter_4src.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_4src.sv
// Four-source round-robin arbiter feeding a registered unidirectional bus.
// Define BUS_PARITY_EN to add the registered even-parity output bus_parity.
module bus_arbiter_4src #(
  parameter int DATA_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            src_valid,
  input  logic [4*DATA_W-1:0]   src_data,
  output logic [3:0]            src_ready,
  output logic [DATA_W-1:0]     bus_data,
  output logic                  bus_valid,
  output logic [1:0]            bus_src,
`ifdef BUS_PARITY_EN
  output logic                  bus_parity,
`endif
  input  logic                  bus_ready
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [DATA_W-1:0]   bus_data_q, bus_data_d;
  logic [1:0]          bus_src_q, bus_src_d;
  logic                bus_valid_q, bus_valid_d;

  logic                win_found;
  logic [1:0]          win_idx;
  logic                accept;
  logic                xfer;
  logic [DATA_W-1:0]   win_data;

  // Search starts at ptr and wraps; first requester wins.
  always_comb begin
    logic [1:0] cand;
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && src_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign accept    = (state_q == IDLE) || bus_ready;
  assign xfer      = rst_n && accept && win_found;
  assign src_ready = xfer ? (4'b0001 << win_idx) : 4'b0000;
  assign win_data  = src_data[win_idx*DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    bus_data_d  = bus_data_q;
    bus_src_d   = bus_src_q;
    bus_valid_d = bus_valid_q;
    if (xfer) begin
      state_d     = BUSY;
      ptr_d       = win_idx + 2'd1;
      bus_data_d  = win_data;
      bus_src_d   = win_idx;
      bus_valid_d = 1'b1;
    end else if (state_q == BUSY && bus_ready) begin
      state_d     = IDLE;
      bus_valid_d = 1'b0;
    end
  end

`ifdef BUS_PARITY_EN
  logic bus_parity_q, bus_parity_d;

  // Parity follows whatever word is loaded so it stays aligned with bus_data.
  always_comb begin
    bus_parity_d = bus_parity_q;
    if (xfer) bus_parity_d = ^win_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) bus_parity_q <= 1'b0;
    else        bus_parity_q <= bus_parity_d;
  end

  assign bus_parity = bus_parity_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      bus_data_q  <= '0;
      bus_src_q   <= 2'd0;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      bus_data_q  <= bus_data_d;
      bus_src_q   <= bus_src_d;
      bus_valid_q <= bus_valid_d;
    end
  end

  assign bus_data  = bus_data_q;
  assign bus_src   = bus_src_q;
  assign bus_valid = bus_valid_q;

endmodule

// File: tb/tb_bus_arbiter_4src.sv
// Directed-vector bench for bus_arbiter_4src; parity checks only when BUS_PARITY_EN is defined.
module tb_bus_arbiter_4src;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src_valid;
  logic [15:0] src_data;
  logic [3:0]  src_ready;
  logic [3:0]  bus_data;
  logic        bus_valid;
  logic [1:0]  bus_src;
  logic        bus_ready;
`ifdef BUS_PARITY_EN
  logic        bus_parity;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_arbiter_4src #(.DATA_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .bus_src   (bus_src),
`ifdef BUS_PARITY_EN
    .bus_parity(bus_parity),
`endif
    .bus_ready (bus_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic v, input logic [1:0] s, input logic [3:0] d);
    chk({tag, ".valid"}, 32'(bus_valid), 32'(v));
    chk({tag, ".src"},   32'(bus_src),   32'(s));
    chk({tag, ".data"},  32'(bus_data),  32'(d));
  endtask

  initial begin
    logic [1:0] exp_src;

    // Reset with every source requesting: no grants may leak out.
    rst_n = 1'b0; src_valid = 4'b1111; src_data = 16'h4321; bus_ready = 1'b1;
    step(); step();
    chk("rst.ready", 32'(src_ready), 32'h0);
    chk_bus("rst", 1'b0, 2'd0, 4'h0);
`ifdef BUS_PARITY_EN
    chk("rst.parity", 32'(bus_parity), 32'h0);
`endif

    // Single request from source 2.
    rst_n = 1'b1; src_valid = 4'b0100; src_data = 16'h0A00; bus_ready = 1'b1;
    #1 chk("single.ready", 32'(src_ready), 32'h4);
    step();
    chk_bus("single", 1'b1, 2'd2, 4'hA);

    // Drain to idle; ptr should now be 3.
    src_valid = 4'b0000;
    #1 chk("drain.ready", 32'(src_ready), 32'h0);
    step();
    chk("drain.valid", 32'(bus_valid), 32'h0);
    src_valid = 4'b1111; src_data = 16'h4321;
    #1 chk("ptr3.ready", 32'(src_ready), 32'h8);

    // Fairness from a fresh reset: 0,1,2,3,0,1,2,3 with no bubble.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; src_valid = 4'b1111; src_data = 16'h4321; bus_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_src = 2'(i);
      #1 chk($sformatf("rr%0d.ready", i), 32'(src_ready), 32'(4'b0001 << exp_src));
      step();
      chk_bus($sformatf("rr%0d", i), 1'b1, exp_src, 4'(exp_src) + 4'h1);
    end

    // Drain, then backpressure on a word from source 1 (ptr is 0).
    src_valid = 4'b0000;
    step();
    chk("bp.idle", 32'(bus_valid), 32'h0);
    src_valid = 4'b0010; src_data = 16'h0050; bus_ready = 1'b0;
    #1 chk("bp.accept", 32'(src_ready), 32'h2);
    step();
    chk_bus("bp.load", 1'b1, 2'd1, 4'h5);
    src_valid = 4'b0110; src_data = 16'h0CE0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("bp%0d.ready", i), 32'(src_ready), 32'h0);
      step();
      chk_bus($sformatf("bp%0d", i), 1'b1, 2'd1, 4'h5);
    end
    bus_ready = 1'b1;
    #1 chk("bp.release.ready", 32'(src_ready), 32'h4);
    step();
    chk_bus("bp.next", 1'b1, 2'd2, 4'hC);

    // Reset while BUSY holding 4'h9 from source 3 (ptr is 3).
    src_valid = 4'b1000; src_data = 16'h9000;
    step();
    chk_bus("mid.load", 1'b1, 2'd3, 4'h9);
    bus_ready = 1'b0; rst_n = 1'b0; src_valid = 4'b0000;
    step();
    chk_bus("mid.rst", 1'b0, 2'd0, 4'h0);
    rst_n = 1'b1; src_valid = 4'b1001; src_data = 16'hB00D; bus_ready = 1'b1;
    #1 chk("mid.after.ready", 32'(src_ready), 32'h1);
    step();
    chk_bus("mid.after", 1'b1, 2'd0, 4'hD);

    // Source 1 holds valid across two transfers: words 7 then 3.
    src_valid = 4'b0010; src_data = 16'h0070;
    step();
    chk_bus("par7", 1'b1, 2'd1, 4'h7);
`ifdef BUS_PARITY_EN
    chk("par7.parity", 32'(bus_parity), 32'h1);
`endif
    src_data = 16'h0030;
    #1 chk("par3.ready", 32'(src_ready), 32'h2);
    step();
    chk_bus("par3", 1'b1, 2'd1, 4'h3);
`ifdef BUS_PARITY_EN
    chk("par3.parity", 32'(bus_parity), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
